// File: rtl/transmission_pkg.sv
// Shared types and constants for the 8-channel transmission sequencer.
// CHAN_MASK_EN adds the next-set-bit helper used for masked scans.
package transmission_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  localparam logic [7:0] IDLE_DATA = 8'hFF;

`ifdef CHAN_MASK_EN
  // {found, index} of the lowest set mask bit strictly above cur
  function automatic logic [SEL_W:0] next_set(
    input logic [NUM_CH-1:0] mask,
    input logic [SEL_W-1:0]  cur
  );
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/transmission_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps at terminal count.
// Synchronous clear has priority over counting.
module transmission_dwell_timer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [DWELL_W-1:0] cnt;

  assign tc = (cnt == DWELL_W'(DWELL - 1));

  // count up while enabled, return to zero on terminal count or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/transmission8_sequencer.sv
// Feeds one word to the 8-channel demux, stepping select {A,B,C} per dwell.
// Optional macro CHAN_MASK_EN: iMask selects which channels are visited.
module transmission8_sequencer
  import transmission_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] iWord,
  input  logic       iValid,
`ifdef CHAN_MASK_EN
  input  logic [7:0] iMask,
`endif
  output logic       oReady,
  output logic [7:0] oData,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic       oActive,
  output logic       oDone
);

  if (DWELL < 1 || DWELL > (2 ** DWELL_W) - 1) begin : g_bad_dwell
    $error("DWELL must be 1..2**DWELL_W-1");
  end

  state_t           state;
  state_t           state_nx;
  logic [7:0]       word_q;
  logic [SEL_W-1:0] chan_q;
  logic [SEL_W-1:0] chan_first;
  logic [SEL_W-1:0] chan_next;
  logic             done_q;
  logic             accept;
  logic             step;
  logic             finish;
  logic             empty;
  logic             last;
  logic             tc;
  logic             en;

`ifdef CHAN_MASK_EN
  logic [7:0]       mask_q;
  logic [SEL_W:0]   nxt_run;
  logic [SEL_W:0]   nxt_new;

  assign nxt_run    = next_set(mask_q, chan_q);
  assign nxt_new    = next_set(iMask, '0);
  assign chan_first = iMask[0] ? '0 : nxt_new[SEL_W-1:0];
  assign chan_next  = nxt_run[SEL_W-1:0];
  assign last       = !nxt_run[SEL_W];
  assign empty      = accept && (iMask == 8'h00);
`else
  assign chan_first = '0;
  assign chan_next  = chan_q + 1'b1;
  assign last       = (chan_q == SEL_W'(NUM_CH - 1));
  assign empty      = 1'b0;
`endif

  transmission_dwell_timer #(
    .DWELL  (DWELL),
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (en),
    .tc   (tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    en       = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iValid) begin
          accept   = 1'b1;
          state_nx = empty ? ST_IDLE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        en = 1'b1;
        if (tc) begin
          if (last) begin
            finish   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // word, channel and done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= IDLE_DATA;
      chan_q <= '0;
      done_q <= 1'b0;
`ifdef CHAN_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      done_q <= finish | empty;
      if (accept) begin
        word_q <= iWord;
        chan_q <= empty ? '0 : chan_first;
`ifdef CHAN_MASK_EN
        mask_q <= iMask;
`endif
      end else if (step) begin
        chan_q <= chan_next;
      end else if (finish) begin
        chan_q <= '0;
      end
    end
  end

  assign oReady         = (state == ST_IDLE);
  assign oActive        = (state == ST_SCAN);
  assign oData          = oActive ? word_q : IDLE_DATA;
  assign {oA, oB, oC}   = chan_q;
  assign oDone          = done_q;

endmodule

// File: tb/tb_transmission8_sequencer.sv
// Directed bench for transmission8_sequencer (DWELL=4 and DWELL=1 instances).
// With CHAN_MASK_EN a DWELL=2 instance exercises masked scans.
module tb_transmission8_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] w4 = 8'h00;
  logic       v4 = 1'b0;
  logic [7:0] w1 = 8'h00;
  logic       v1 = 1'b0;
  logic       r4, a4, b4, c4, act4, dn4;
  logic [7:0] d4;
  logic       r1, a1, b1, c1, act1, dn1;
  logic [7:0] d1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

`ifdef CHAN_MASK_EN
  logic [7:0] w2 = 8'h00;
  logic       v2 = 1'b0;
  logic [7:0] m2 = 8'h00;
  logic       r2, a2, b2, c2, act2, dn2;
  logic [7:0] d2;
`endif

  transmission8_sequencer #(.DWELL(4), .DWELL_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .iWord(w4), .iValid(v4),
`ifdef CHAN_MASK_EN
    .iMask(8'hFF),
`endif
    .oReady(r4), .oData(d4), .oA(a4), .oB(b4), .oC(c4),
    .oActive(act4), .oDone(dn4)
  );

  transmission8_sequencer #(.DWELL(1), .DWELL_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .iWord(w1), .iValid(v1),
`ifdef CHAN_MASK_EN
    .iMask(8'hFF),
`endif
    .oReady(r1), .oData(d1), .oA(a1), .oB(b1), .oC(c1),
    .oActive(act1), .oDone(dn1)
  );

`ifdef CHAN_MASK_EN
  transmission8_sequencer #(.DWELL(2), .DWELL_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .iWord(w2), .iValid(v2),
    .iMask(m2),
    .oReady(r2), .oData(d2), .oA(a2), .oB(b2), .oC(c2),
    .oActive(act2), .oDone(dn2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // idle-value check on the DWELL=4 instance
  task automatic idle4(input string tag, input logic done);
    chk({tag, ".rdy"}, 32'(r4), 32'd1);
    chk({tag, ".act"}, 32'(act4), 32'd0);
    chk({tag, ".done"}, 32'(dn4), 32'(done));
    chk({tag, ".data"}, 32'(d4), 32'hFF);
    chk({tag, ".sel"}, 32'({a4, b4, c4}), 32'd0);
  endtask

  initial begin
    // power-on reset, checked asynchronously before any clock edge
    #1;
    idle4("por", 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    idle4("post_rst", 1'b0);

    // single word A5, DWELL=4: channel k on cycles 1+4k..4+4k
    w4 = 8'hA5;
    v4 = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      cyc();
      v4 = 1'b0;
      if (c <= 32) begin
        chk("a5.sel", 32'({a4, b4, c4}), 32'((c - 1) / 4));
        chk("a5.data", 32'(d4), 32'hA5);
        chk("a5.act", 32'(act4), 32'd1);
        chk("a5.rdy", 32'(r4), 32'd0);
        chk("a5.done", 32'(dn4), 32'd0);
      end else if (c == 33) begin
        idle4("a5.end", 1'b1);
      end else begin
        idle4("a5.after", 1'b0);
      end
    end

    // back-to-back 3C then C3 with iValid held high throughout
    w4 = 8'h3C;
    v4 = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      cyc();
      if (c == 1) w4 = 8'hC3;
      if (c == 34) v4 = 1'b0;
      if (c <= 32) begin
        chk("b2b1.data", 32'(d4), 32'h3C);
        chk("b2b1.sel", 32'({a4, b4, c4}), 32'((c - 1) / 4));
      end else if (c == 33) begin
        chk("b2b.done", 32'(dn4), 32'd1);
        chk("b2b.rdy", 32'(r4), 32'd1);
        chk("b2b.act", 32'(act4), 32'd0);
      end else if (c <= 65) begin
        chk("b2b2.data", 32'(d4), 32'hC3);
        chk("b2b2.act", 32'(act4), 32'd1);
        chk("b2b2.sel", 32'({a4, b4, c4}), 32'((c - 34) / 4));
        chk("b2b2.done", 32'(dn4), 32'd0);
      end else if (c == 66) begin
        idle4("b2b2.end", 1'b1);
      end else begin
        idle4("b2b2.after", 1'b0);
      end
    end

    // DWELL=1: select steps every cycle, done at N+9
    w1 = 8'h5A;
    v1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      v1 = 1'b0;
      if (c <= 8) begin
        chk("d1.sel", 32'({a1, b1, c1}), 32'(c - 1));
        chk("d1.act", 32'(act1), 32'd1);
        chk("d1.data", 32'(d1), 32'h5A);
        chk("d1.done", 32'(dn1), 32'd0);
      end else begin
        chk("d1.done_end", 32'(dn1), 32'(c == 9));
        chk("d1.act_end", 32'(act1), 32'd0);
        chk("d1.rdy_end", 32'(r1), 32'd1);
      end
    end

    // reset while channel 3 is presented
    w4 = 8'h77;
    v4 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      v4 = 1'b0;
    end
    chk("rst.pre_sel", 32'({a4, b4, c4}), 32'd3);
    chk("rst.pre_act", 32'(act4), 32'd1);
    rst_n = 1'b0;
    #1;
    idle4("rst.mid", 1'b0);
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cyc();
      chk("rst.nodone", 32'(dn4), 32'd0);
      chk("rst.idle", 32'(act4), 32'd0);
    end
    w4 = 8'h11;
    v4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      v4 = 1'b0;
      chk("rst.restart_sel", 32'({a4, b4, c4}), 32'((c - 1) / 4));
      chk("rst.restart_data", 32'(d4), 32'h11);
    end
    for (int c = 6; c <= 33; c++) cyc();
    idle4("rst.restart_end", 1'b1);

`ifdef CHAN_MASK_EN
    // masked scan: channels 0,2,7 for two cycles each
    w2 = 8'h96;
    m2 = 8'b1000_0101;
    v2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      v2 = 1'b0;
      if (c <= 6) begin
        chk("mask.sel", 32'({a2, b2, c2}), (c <= 2) ? 32'd0 : (c <= 4) ? 32'd2 : 32'd7);
        chk("mask.act", 32'(act2), 32'd1);
        chk("mask.data", 32'(d2), 32'h96);
      end else begin
        chk("mask.done", 32'(dn2), 32'(c == 7));
        chk("mask.act_end", 32'(act2), 32'd0);
      end
    end
    // empty mask: no scan, done right away
    m2 = 8'h00;
    v2 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      v2 = 1'b0;
      chk("mask0.done", 32'(dn2), 32'(c == 1));
      chk("mask0.act", 32'(act2), 32'd0);
      chk("mask0.data", 32'(d2), 32'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
